// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, frame FSM states and counter sizing.
// Used by the transmitter now and by the planned receiver.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } uart_state_e;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// With CLKS_PER_BIT=1 the counter stays at zero and bit_done_o is permanently high.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic bit_done_o
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign bit_done_o = (count_q == LAST);

    always_comb begin
        count_d = count_q + CW'(1);
        if (clear_i || bit_done_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per valid/ready handshake, framed as
// start / data (LSB first) / optional parity / stop bits, with back-to-back streaming.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o
);

    localparam int BW = cnt_width(DATA_BITS);
    localparam int SW = cnt_width(STOP_BITS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [SW-1:0] LAST_STOP = SW'(STOP_BITS - 1);
    localparam logic          PAR_INIT  = (PARITY == PARITY_ODD);

    uart_state_e          state_q,    state_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [BW-1:0]        bit_idx_q,  bit_idx_d;
    logic [SW-1:0]        stop_idx_q, stop_idx_d;
    logic                 parity_q,   parity_d;
    logic                 tx_q,       tx_d;
    logic                 bit_done;
    logic                 last_stop_cycle;
    logic                 accept;

    // Held clear while idle so the start bit always gets a full period.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == IDLE),
        .bit_done_o(bit_done)
    );

    assign last_stop_cycle = (state_q == STOP) && bit_done && (stop_idx_q == LAST_STOP);
    assign ready_o         = (state_q == IDLE) || last_stop_cycle;
    assign accept          = valid_i && ready_o;
    assign busy_o          = (state_q != IDLE);
    assign tx_o            = tx_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d  = START;
                    tx_d     = 1'b0;
                    shift_d  = data_in_i;
                    parity_d = PAR_INIT;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    // Parity accumulates each data bit as it leaves the line.
                    parity_d = parity_q ^ shift_q[0];
                    shift_d  = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        if (PARITY != PARITY_NONE) begin
                            state_d = PAR;
                            tx_d    = parity_q ^ shift_q[0];
                        end else begin
                            state_d    = STOP;
                            stop_idx_d = '0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                        tx_d      = shift_q[1];
                    end
                end
            end
            PAR: begin
                if (bit_done) begin
                    state_d    = STOP;
                    stop_idx_d = '0;
                    tx_d       = 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (stop_idx_q == LAST_STOP) begin
                        if (accept) begin
                            state_d  = START;
                            tx_d     = 1'b0;
                            shift_d  = data_in_i;
                            parity_d = PAR_INIT;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_idx_d = stop_idx_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Runs several uart_tx_frame configurations side by side against a per-cycle
// frame model built from the word, bit period and frame format.
module tb_uart_tx_frame;

    localparam int NI   = 5;
    localparam int NDIR = 6;
    localparam int CPB_T [NI] = '{4, 4, 4, 2, 1};
    localparam int DB_T  [NI] = '{8, 8, 8, 7, 8};
    localparam int PAR_T [NI] = '{0, 2, 1, 0, 0};
    localparam int SB_T  [NI] = '{1, 1, 1, 2, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic       tx_w    [NI];
    logic       ready_w [NI];
    logic       busy_w  [NI];
    logic [8:0] dir_words [NDIR] = '{9'h0A5, 9'h001, 9'h000, 9'h0FF, 9'h07F, 9'h03C};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Line levels of one frame, bit 0 first; unused positions stay at the stop level.
    function automatic logic [15:0] frame_bits(input logic [8:0] w, input int db, input int par);
        logic [15:0] b;
        logic        p;
        b    = '1;
        b[0] = 1'b0;
        p    = (par == 1);
        for (int i = 0; i < db; i++) begin
            b[1+i] = w[i];
            p      = p ^ w[i];
        end
        if (par != 0) b[1+db] = p;
        return b;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gen_dut
        localparam int CPB  = CPB_T[g];
        localparam int DB   = DB_T[g];
        localparam int PAR  = PAR_T[g];
        localparam int SB   = SB_T[g];
        localparam int FLEN = CPB * (1 + DB + ((PAR != 0) ? 1 : 0) + SB);

        logic [8:0]  data_v = '0;
        logic        valid_v = 1'b0;
        logic        tx, rdy, bsy;
        logic [15:0] m_bits = '1;
        int          m_cyc = 0;
        int          m_idx = 0;
        bit          m_busy = 1'b0;
        logic        m_ready;

        assign m_ready = !m_busy || (m_cyc == FLEN - 1);

        uart_tx_frame #(
            .CLKS_PER_BIT(CPB),
            .DATA_BITS   (DB),
            .PARITY      (PAR),
            .STOP_BITS   (SB)
        ) u_dut (
            .clk      (clk),
            .reset    (rst_n),
            .data_in_i(data_v[DB-1:0]),
            .valid_i  (valid_v),
            .ready_o  (rdy),
            .tx_o     (tx),
            .busy_o   (bsy)
        );

        assign tx_w[g]    = tx;
        assign ready_w[g] = rdy;
        assign busy_w[g]  = bsy;

        // Reference: a frame is a list of bit levels, each held CPB cycles.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_busy <= 1'b0;
                m_cyc  <= 0;
                if (m_idx != 0) m_idx <= NDIR - 1;
            end else if (valid_v && m_ready) begin
                m_bits <= frame_bits(data_v, DB, PAR);
                m_cyc  <= 0;
                m_busy <= 1'b1;
                m_idx  <= m_idx + 1;
            end else if (m_busy) begin
                if (m_cyc == FLEN - 1) m_busy <= 1'b0;
                else m_cyc <= m_cyc + 1;
            end
        end

        always @(negedge clk) begin
            check_eq($sformatf("tx%0d", g), 32'(tx), 32'(m_busy ? m_bits[m_cyc / CPB] : 1'b1));
            check_eq($sformatf("ready%0d", g), 32'(rdy), 32'(m_ready));
            check_eq($sformatf("busy%0d", g), 32'(bsy), 32'(m_busy));
            if (m_ready) begin
                valid_v = (m_idx < NDIR) ? 1'b1 : ($urandom_range(3) != 0);
                data_v  = (m_idx < NDIR) ? dir_words[m_idx] : 9'($urandom);
            end else begin
                // Garbage offered while busy must never reach the line.
                valid_v = 1'($urandom_range(1));
                data_v  = 9'($urandom);
            end
        end
    end

    initial begin
        bit found;
        found = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Abort instance 0 during data bit 3 of its fifth directed frame (0x7F).
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (gen_dut[0].m_idx == 5 && gen_dut[0].m_busy && (gen_dut[0].m_cyc / 4) == 4)
                found = 1'b1;
        end
        check_eq("mid_frame_reached", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            check_eq($sformatf("rst_tx%0d", g), 32'(tx_w[g]), 32'd1);
            check_eq($sformatf("rst_busy%0d", g), 32'(busy_w[g]), 32'd0);
            check_eq($sformatf("rst_ready%0d", g), 32'(ready_w[g]), 32'd1);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        repeat (3000) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
